// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and a width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, modulo N_REQ.
module uart_tx_arbiter_rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any_req
);

  always_comb begin
    logic [IDW-1:0] k;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    k       = '0;
    // Explicit modulo keeps the scan correct for non-power-of-two N_REQ.
    for (int i = 0; i < N_REQ; i++) begin
      k = IDW'((int'(ptr) + i) % N_REQ);
      if (!any_req && req[k]) begin
        any_req = 1'b1;
        idx     = k;
      end
    end
    if (any_req) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte requesters with round-robin
// arbitration, frame tracking, busy-rise timeout and an inter-frame gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int IDW          = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              io_i_req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] io_i_req_data,
  output logic [N_REQ-1:0]              io_o_req_ready,
  output logic                          io_o_tx_trig,
  output logic [PAYLOAD_BITS-1:0]       io_o_tx_data,
  input  logic                          io_i_tx_busy,
  input  logic                          io_i_tx_done,
  output logic [IDW-1:0]                io_o_grant_id,
  output logic                          io_o_frame_done,
  output logic                          io_o_timeout,
  output logic                          io_o_active
);

  localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CW      = clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                  state;
  logic [IDW-1:0]          rr_ptr;
  logic [CW-1:0]           cnt;
  logic                    busy_q;
  logic [N_REQ-1:0]        grant;
  logic [IDW-1:0]          win_idx;
  logic                    any_req;
  logic [PAYLOAD_BITS-1:0] win_data;
  logic                    accept;
  logic                    done_evt;
  logic                    busy_expired;

  uart_tx_arbiter_rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (io_i_req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .idx    (win_idx),
    .any_req(any_req)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == IDW'(k)) win_data = io_i_req_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Handshake: a byte moves when valid[k] & ready[k]; ready is only ever raised
  // in IDLE with the transmitter idle, and only for the round-robin winner.
  assign accept         = !reset && (state == IDLE) && any_req && !io_i_tx_busy;
  assign io_o_req_ready = accept ? grant : '0;

  // A frame ends on tx_done or on busy falling; either way it is a single pulse.
  assign done_evt     = !reset && (state == WAIT_DONE) &&
                        (io_i_tx_done || (busy_q && !io_i_tx_busy));
  assign busy_expired = !reset && (state == WAIT_BUSY) && !io_i_tx_busy && (cnt == BUSY_LAST);
  assign io_o_frame_done = done_evt;
  assign io_o_timeout    = busy_expired;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      busy_q        <= 1'b0;
      io_o_tx_trig  <= 1'b0;
      io_o_tx_data  <= '0;
      io_o_grant_id <= '0;
      io_o_active   <= 1'b0;
    end else begin
      busy_q       <= io_i_tx_busy;
      io_o_tx_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            io_o_tx_data  <= win_data;
            io_o_grant_id <= win_idx;
            rr_ptr        <= (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            io_o_tx_trig  <= 1'b1;
            io_o_active   <= 1'b1;
            state         <= TRIG;
          end
        end
        TRIG: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (io_i_tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_expired) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done_evt) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            io_o_active <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural UART stand-in plus an event-time
// reference model of grants, trigger, frame end, timeout and gap timing.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int PB  = 8;
  localparam int G   = 5;
  localparam int BT  = 16;
  localparam int IDW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      io_i_req_valid;
  logic [N*PB-1:0]   io_i_req_data;
  logic [N-1:0]      io_o_req_ready;
  logic              io_o_tx_trig;
  logic [PB-1:0]     io_o_tx_data;
  logic              io_i_tx_busy;
  logic              io_i_tx_done;
  logic [IDW-1:0]    io_o_grant_id;
  logic              io_o_frame_done;
  logic              io_o_timeout;
  logic              io_o_active;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .N_REQ(N), .PAYLOAD_BITS(PB), .GAP_CYCLES(G), .BUSY_TIMEOUT(BT), .IDW(IDW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_i_req_valid (io_i_req_valid),
    .io_i_req_data  (io_i_req_data),
    .io_o_req_ready (io_o_req_ready),
    .io_o_tx_trig   (io_o_tx_trig),
    .io_o_tx_data   (io_o_tx_data),
    .io_i_tx_busy   (io_i_tx_busy),
    .io_i_tx_done   (io_i_tx_done),
    .io_o_grant_id  (io_o_grant_id),
    .io_o_frame_done(io_o_frame_done),
    .io_o_timeout   (io_o_timeout),
    .io_o_active    (io_o_active)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [PB-1:0] exp_q[$];
  int            gid_log[$];
  logic [PB-1:0] byte_log[$];

  // Stimulus knobs
  logic          rst_v;
  logic [N-1:0]  valid_v;
  logic [N*PB-1:0] data_v;
  bit            force_busy, disconnect, auto_drop, fixed_plan;

  // Reference model state
  int            ref_ptr, ref_free, ref_t, ref_e, ref_w;
  bit            ref_to;
  logic [PB-1:0] ref_byte;
  int            pl_d, pl_f, pl_mode;
  bit            pl_spur, pl_on, pl_disc;

  int fd_count, to_count, rdy_count, last_fd, gap_meas, last_trig, to_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic         busy_drv, done_drv;
    logic [N-1:0] exp_ready;
    int           w;
    @(negedge clock);
    // UART stand-in: busy window and done pulse follow the plan chosen at accept.
    busy_drv = force_busy;
    done_drv = 1'b0;
    if (pl_on && !pl_disc) begin
      if (cyc >= ref_t + 1 + pl_d && cyc <= ref_t + pl_d + pl_f) busy_drv = 1'b1;
      if (pl_mode == 0 && cyc == ref_t + pl_d + pl_f) done_drv = 1'b1;
      if (pl_mode == 2 && cyc == ref_t + pl_d + pl_f + 1) done_drv = 1'b1;
      if (pl_spur && cyc == ref_t + 1) done_drv = 1'b1;
    end
    reset          = rst_v;
    io_i_tx_busy   = busy_drv;
    io_i_tx_done   = done_drv;
    io_i_req_valid = valid_v;
    io_i_req_data  = data_v;
    #1;
    if (rst_v) begin
      ref_ptr  = 0;
      ref_t    = -1;
      ref_e    = -1;
      ref_free = cyc + 1;
      pl_on    = 1'b0;
      exp_q.delete();
    end else begin
      w = -1;
      if (cyc >= ref_free && !busy_drv) begin
        for (int j = 0; j < N; j++) begin
          int k;
          k = (ref_ptr + j) % N;
          if (w < 0 && valid_v[k]) w = k;
        end
      end
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      check("ready", 32'(io_o_req_ready), 32'(exp_ready));
      check("trig", 32'(io_o_tx_trig), 32'(cyc == ref_t));
      check("frame_done", 32'(io_o_frame_done), 32'(cyc == ref_e && !ref_to));
      check("timeout", 32'(io_o_timeout), 32'(cyc == ref_e && ref_to));
      check("active", 32'(io_o_active), 32'(ref_t >= 0 && cyc >= ref_t && cyc < ref_free));
      if (io_o_frame_done) begin fd_count++; last_fd = cyc; end
      if (io_o_timeout) begin to_count++; to_delay = cyc - last_trig; end
      if (io_o_tx_trig) last_trig = cyc;
      if (|io_o_req_ready) begin
        rdy_count++;
        if (last_fd >= 0) begin gap_meas = cyc - last_fd; last_fd = -1; end
      end
      if (cyc == ref_t) begin
        if (exp_q.size() > 0) check("sb_byte", 32'(io_o_tx_data), 32'(exp_q.pop_front()));
        else check("sb_size", 32'(exp_q.size()), 32'd1);
        byte_log.push_back(io_o_tx_data);
        gid_log.push_back(int'(io_o_grant_id));
      end
      if (ref_t >= 0 && cyc >= ref_t) begin
        check("grant_id", 32'(io_o_grant_id), 32'(ref_w));
        check("tx_data_hold", 32'(io_o_tx_data), 32'(ref_byte));
      end
      if (w >= 0) begin
        ref_byte = data_v[w*PB +: PB];
        exp_q.push_back(ref_byte);
        ref_w   = w;
        ref_ptr = (w + 1) % N;
        ref_t   = cyc + 1;
        if (fixed_plan) begin
          pl_d = 0; pl_f = 4; pl_mode = 0; pl_spur = 1'b0;
        end else begin
          pl_d    = $urandom_range(0, 3);
          pl_f    = $urandom_range(2, 5);
          pl_mode = $urandom_range(0, 2);
          pl_spur = (pl_d >= 1) && ($urandom_range(0, 1) == 1);
        end
        pl_disc = disconnect;
        pl_on   = 1'b1;
        ref_to  = pl_disc;
        if (pl_disc) ref_e = ref_t + BT;
        else if (pl_mode == 0) ref_e = ref_t + pl_d + pl_f;
        else ref_e = ref_t + pl_d + pl_f + 1;
        ref_free = ref_e + G + 1;
        if (auto_drop) valid_v[w] = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic wait_frames(input int n);
    int b;
    b = 0;
    while ((gid_log.size() < n || cyc < ref_free) && b < 400) begin
      tick();
      b++;
    end
    check("frames_seen", 32'(gid_log.size()), 32'(n));
  endtask

  task automatic clear_logs();
    gid_log.delete();
    byte_log.delete();
    fd_count = 0; to_count = 0; rdy_count = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 32'(io_o_req_ready), 32'd0);
    check({tag, "_trig"}, 32'(io_o_tx_trig), 32'd0);
    check({tag, "_tx_data"}, 32'(io_o_tx_data), 32'd0);
    check({tag, "_grant_id"}, 32'(io_o_grant_id), 32'd0);
    check({tag, "_frame_done"}, 32'(io_o_frame_done), 32'd0);
    check({tag, "_timeout"}, 32'(io_o_timeout), 32'd0);
    check({tag, "_active"}, 32'(io_o_active), 32'd0);
  endtask

  initial begin
    int exp_g[5];
    int start;
    logic [PB-1:0] exp_b[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    reset = 1'b1; io_i_req_valid = '0; io_i_req_data = '0;
    io_i_tx_busy = 1'b0; io_i_tx_done = 1'b0;
    rst_v = 1'b1; valid_v = '0; data_v = '0;
    force_busy = 1'b0; disconnect = 1'b0; auto_drop = 1'b0; fixed_plan = 1'b1;
    ref_ptr = 0; ref_free = 0; ref_t = -1; ref_e = -1; ref_w = 0; ref_to = 1'b0; ref_byte = '0;
    pl_d = 0; pl_f = 2; pl_mode = 0; pl_spur = 1'b0; pl_on = 1'b0; pl_disc = 1'b0;
    last_fd = -1; gap_meas = -1; last_trig = 0; to_delay = -1;
    clear_logs();

    repeat (3) tick();
    rst_v = 1'b0;
    tick();
    check_outputs_zero("reset");

    // All requesters valid: rotation 0,1,2,3,0 and gap timing.
    data_v  = {8'h13, 8'h12, 8'h11, 8'h10};
    valid_v = 4'hF;
    clear_logs();
    wait_frames(5);
    valid_v = '0;
    wait_frames(gid_log.size());
    for (int i = 0; i < 5; i++) begin
      if (i < gid_log.size()) begin
        check("rr_order", 32'(gid_log[i]), 32'(exp_g[i]));
        check("rr_byte", 32'(byte_log[i]), 32'(exp_b[i]));
      end
    end
    check("gap_to_ready", 32'(gap_meas), 32'(G + 1));

    // Single request on requester 2.
    clear_logs();
    auto_drop = 1'b1;
    data_v[2*PB +: PB] = 8'hAB;
    valid_v = 4'b0100;
    wait_frames(1);
    check("single_gid", 32'(gid_log[0]), 32'd2);
    check("single_byte", 32'(byte_log[0]), 32'hAB);
    check("single_fd_count", 32'(fd_count), 32'd1);
    check("single_ready_count", 32'(rdy_count), 32'd1);

    // Transmitter disconnected for the first frame: timeout, then next requester.
    clear_logs();
    disconnect = 1'b1;
    valid_v = 4'b0011;
    start = cyc;
    while (gid_log.size() < 1 && cyc < start + 100) tick();
    disconnect = 1'b0;
    wait_frames(2);
    check("to_count", 32'(to_count), 32'd1);
    check("to_delay", 32'(to_delay), 32'(BT));
    check("to_fd_count", 32'(fd_count), 32'd1);
    if (gid_log.size() >= 2) begin
      check("to_gid0", 32'(gid_log[0]), 32'd0);
      check("to_gid1", 32'(gid_log[1]), 32'd1);
    end

    // Transmitter busy from outside: no accept until it drops.
    clear_logs();
    force_busy = 1'b1;
    valid_v = 4'b0001;
    repeat (6) tick();
    check("busy_hold_ready", 32'(rdy_count), 32'd0);
    force_busy = 1'b0;
    wait_frames(1);
    check("busy_release_gid", 32'(gid_log[0]), 32'd0);

    // Reset in the middle of WAIT_DONE.
    clear_logs();
    valid_v = 4'b1000;
    start = cyc;
    while (gid_log.size() < 1 && cyc < start + 100) tick();
    while (cyc < ref_t + 3 && cyc < start + 100) tick();
    check("pre_reset_active", 32'(io_o_active), 32'd1);
    rst_v = 1'b1;
    valid_v = '0;
    tick();
    rst_v = 1'b0;
    tick();
    check_outputs_zero("midreset");
    clear_logs();
    valid_v = 4'b1010;
    wait_frames(1);
    check("post_reset_gid", 32'(gid_log[0]), 32'd1);
    valid_v = '0;
    wait_frames(gid_log.size());

    // Randomized traffic against the reference model.
    fixed_plan = 1'b0;
    auto_drop  = 1'b0;
    for (int i = 0; i < 500; i++) begin
      valid_v    = N'($urandom_range(0, 15));
      data_v     = (N*PB)'($urandom());
      disconnect = ($urandom_range(0, 9) == 0);
      force_busy = (cyc >= ref_free) && ($urandom_range(0, 7) == 0);
      tick();
    end
    valid_v = '0;
    force_busy = 1'b0;
    disconnect = 1'b0;
    start = cyc;
    while (cyc < ref_free + 2 && cyc < start + 100) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single UART_tx transmitter among N_REQ byte requesters. Requesters use round-robin arbitration and a valid/ready handshake. For each accepted byte the block generates the one-cycle io_i_tx_trig pulse and holds the transmitter's data input. It then tracks tx_busy/tx_done until the frame completes and enforces a programmable inter-frame gap. It sits in the tx clock domain between client logic and the UART_tx instance, driving its io_i_tx_trig/io_i_data and observing its io_o_tx_busy/io_o_tx_done.

Parameters:
N_REQ, 4, number of requesters (2..8)
PAYLOAD_BITS, 8, byte width; must match the UART_tx instance
GAP_CYCLES, 2, idle clocks inserted after each frame before the next grant (0 allowed)
BUSY_TIMEOUT, 16, max clocks to wait for tx_busy to rise after trig
IDW, 2, grant index width, equal to ceil(log2(N_REQ))

Ports:
clock  in  1  single clock (tx domain)
reset  in  1  synchronous, active-high reset
io_i_req_valid  in  N_REQ  per-requester byte valid
io_i_req_data  in  N_REQ*PAYLOAD_BITS  requester k's byte is in bits [k*PAYLOAD_BITS +: PAYLOAD_BITS]
io_o_req_ready  out  N_REQ  one-hot accept; a transfer occurs when valid&ready
io_o_tx_trig  out  1  to UART_tx io_i_tx_trig; one-cycle pulse
io_o_tx_data  out  PAYLOAD_BITS  to UART_tx io_i_data; held stable from accept until frame end
io_i_tx_busy  in  1  from UART_tx io_o_tx_busy
io_i_tx_done  in  1  from UART_tx io_o_tx_done
io_o_grant_id  out  IDW  index of the requester currently owning the transmitter
io_o_frame_done  out  1  one-cycle pulse when the granted frame completes
io_o_timeout  out  1  one-cycle pulse when tx_busy never rose
io_o_active  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, and all outputs 0, including tx_data and grant_id.
- States: IDLE, TRIG, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: the winner is the first k with valid[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ. Accept only if io_i_tx_busy=0.
  - On accept: ready[k]=1 combinationally in the same cycle.
  - The byte is latched into tx_data and grant_id<=k.
  - rr_ptr<=k+1 mod N_REQ, then go to TRIG.
  - No valid, or tx_busy=1: ready stays all zero and state stays IDLE.
- TRIG: tx_trig=1 for exactly this one cycle, then go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT-1 with no busy: pulse timeout, go to GAP. The byte is dropped and frame_done is not pulsed.
- WAIT_DONE: on tx_done=1, or on tx_busy falling (1 then 0), pulse frame_done and go to GAP. Only one frame_done pulse is produced even if both events occur together.
- GAP: count GAP_CYCLES clocks, then go to IDLE. With GAP_CYCLES=0, go to IDLE on the next clock.
- Latency: accept to tx_trig is exactly 1 clock. Back-to-back accepts are separated by at least 3+GAP_CYCLES+frame length.
- Handshake:
  - ready is never asserted outside IDLE.
  - A requester may drop valid before acceptance without penalty.
  - Data is sampled only on the accept cycle.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,... and no requester waits more than N_REQ-1 frames.
- tx_done seen in IDLE, GAP or WAIT_BUSY is ignored.
- Reset asserted mid-frame: the block returns to IDLE next clock. The UART_tx instance shares the same reset and is not otherwise aborted.
- Widths: counters are sized to clog2(max(GAP_CYCLES,BUSY_TIMEOUT)+1). rr_ptr wrap is explicit modulo N_REQ, which handles non-power-of-two N_REQ.

Decomposition:
- Shared package: state encoding constants (IDLE=0, TRIG=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4) and a clog2 helper constant function.
- One natural sub-module: rr_arbiter. Inputs are the req vector and the pointer; outputs are the one-hot grant, the index and any_req. It is purely combinational, and the pointer is registered in the parent.

Test Plan:
- Reset then single request: valid[2]=1 with data 0xAB. Expect ready[2] for 1 cycle, tx_trig 1 cycle later, tx_data=0xAB, grant_id=2, and UART_rx receiving 0xAB. frame_done pulses once.
- All four valid continuously, data 0x10..0x13. Expect grant order 0,1,2,3,0 and received bytes 0x10,0x11,0x12,0x13,0x10.
- GAP_CYCLES=5. Measure from the frame_done pulse to the next ready: exactly 5+1 clocks.
- Tie tx_busy low, i.e. disconnect UART_tx. Expect timeout pulse 16 clocks after trig, no frame_done, return to IDLE, and the next requester served.
- Hold tx_busy high externally while valid[0]=1. Expect no ready until busy drops, then accept.
- Assert reset during WAIT_DONE. Expect all outputs 0 next clock, rr_ptr=0, and a fresh request accepted normally after reset.
